health_tracker: RTL and testbench

//  Downstream consumer of the collision stage's current_health_update level.

---
 rtl/health_tracker.sv | 129 ++++++++++++
 tb/tb_health_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/health_tracker.sv
// Ship health tracker: turns hit rises into single points of damage and
// runs the post-hit invulnerability window with a blinking sprite.
module health_tracker #(
    parameter int MAX_HEALTH    = 5,
    parameter int HEALTH_W      = 4,
    parameter int INVULN_CYCLES = 25_000_000,
    parameter int BLINK_DIV     = 3_125_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hit,
    input  logic                heal,
    output logic [HEALTH_W-1:0] health,
    output logic                damage_pulse,
    output logic                invulnerable,
    output logic                ship_visible,
    output logic                game_over
);

    localparam int INV_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [INV_W-1:0]    INV_LOAD = INV_W'(INVULN_CYCLES - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [HEALTH_W-1:0] HMAX     = HEALTH_W'(MAX_HEALTH);

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                hit_d;
    logic                rise;
    logic [INV_W-1:0]    inv_cnt;
    logic [INV_W-1:0]    inv_cnt_n;
    logic [BLK_W-1:0]    blink_cnt;
    logic [BLK_W-1:0]    blink_cnt_n;
    logic [HEALTH_W-1:0] health_n;
    logic [HEALTH_W-1:0] health_inc;
    logic                damage_n;
    logic                visible_n;

    assign rise       = hit & ~hit_d;
    assign health_inc = (health >= HMAX) ? HMAX : health + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ALIVE;
            health       <= HMAX;
            hit_d        <= 1'b1;
            inv_cnt      <= '0;
            blink_cnt    <= '0;
            damage_pulse <= 1'b0;
            invulnerable <= 1'b0;
            ship_visible <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            health       <= health_n;
            hit_d        <= hit;
            inv_cnt      <= inv_cnt_n;
            blink_cnt    <= blink_cnt_n;
            damage_pulse <= damage_n;
            invulnerable <= (state_n == INVULN);
            ship_visible <= visible_n;
            game_over    <= (state_n == DEAD);
        end
    end

    always_comb begin
        state_n     = state;
        health_n    = health;
        inv_cnt_n   = inv_cnt;
        blink_cnt_n = blink_cnt;
        damage_n    = 1'b0;
        visible_n   = ship_visible;
        unique case (state)
            ALIVE: begin
                visible_n = 1'b1;
                if (rise) begin
                    damage_n    = 1'b1;
                    inv_cnt_n   = INV_LOAD;
                    blink_cnt_n = '0;
                    // a simultaneous pickup cancels the damage, so never fatal
                    if (heal) begin
                        state_n = INVULN;
                    end else if (health <= 1) begin
                        health_n = '0;
                        state_n  = DEAD;
                    end else begin
                        health_n = health - 1'b1;
                        state_n  = INVULN;
                    end
                end else if (heal) begin
                    health_n = health_inc;
                end
            end
            INVULN: begin
                if (heal) begin
                    health_n = health_inc;
                end
                if (inv_cnt == '0) begin
                    state_n     = ALIVE;
                    visible_n   = 1'b1;
                    blink_cnt_n = '0;
                end else begin
                    inv_cnt_n = inv_cnt - 1'b1;
                    if (blink_cnt == BLK_LAST) begin
                        blink_cnt_n = '0;
                        visible_n   = ~ship_visible;
                    end else begin
                        blink_cnt_n = blink_cnt + 1'b1;
                    end
                end
            end
            DEAD: begin
                health_n  = '0;
                visible_n = 1'b1;
            end
            default: begin
                state_n = ALIVE;
            end
        endcase
    end

endmodule

// File: tb/tb_health_tracker.sv
// Self-checking bench for health_tracker: table vectors plus
// model-scored sequences for the multi-cycle corner cases.
module tb_health_tracker;

    localparam int MAXH = 3;
    localparam int NINV = 8;
    localparam int BDIV = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hit   = 1'b0;
    logic       heal  = 1'b0;
    logic [3:0] health;
    logic       damage_pulse;
    logic       invulnerable;
    logic       ship_visible;
    logic       game_over;

    health_tracker #(
        .MAX_HEALTH   (MAXH),
        .HEALTH_W     (4),
        .INVULN_CYCLES(NINV),
        .BLINK_DIV    (BDIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hit         (hit),
        .heal        (heal),
        .health      (health),
        .damage_pulse(damage_pulse),
        .invulnerable(invulnerable),
        .ship_visible(ship_visible),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] health;
        logic       dp;
        logic       inv;
        logic       vis;
        logic       go;
    } exp_t;

    typedef struct {
        logic rst;
        logic hit;
        logic heal;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // reference model: elapsed-time view of the invulnerability window
    int m_health = MAXH;
    int m_st     = 0;
    int m_t      = 0;
    bit m_dp     = 0;
    bit m_hd     = 1;

    function automatic exp_t mk(int h, bit dp, bit inv, bit vis, bit go);
        exp_t e;
        e.health = 4'(h);
        e.dp     = dp;
        e.inv    = inv;
        e.vis    = vis;
        e.go     = go;
        return e;
    endfunction

    function automatic vec_t mv(bit r, bit h, bit he, exp_t e);
        vec_t v;
        v.rst  = r;
        v.hit  = h;
        v.heal = he;
        v.e    = e;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit h, input bit he);
        bit rise;
        if (r) begin
            m_health = MAXH;
            m_st     = 0;
            m_t      = 0;
            m_dp     = 0;
            m_hd     = 1;
        end else begin
            rise = h && !m_hd;
            m_hd = h;
            m_dp = 0;
            case (m_st)
                0: begin
                    if (rise) begin
                        m_dp = 1;
                        if (he) begin
                            m_st = 1;
                            m_t  = 0;
                        end else if (m_health == 1) begin
                            m_health = 0;
                            m_st     = 2;
                        end else begin
                            m_health = m_health - 1;
                            m_st     = 1;
                            m_t      = 0;
                        end
                    end else if (he && m_health < MAXH) begin
                        m_health = m_health + 1;
                    end
                end
                1: begin
                    if (he && m_health < MAXH) m_health = m_health + 1;
                    m_t = m_t + 1;
                    if (m_t == NINV) m_st = 0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_exp();
        bit vis;
        vis = (m_st == 1) ? (((m_t / BDIV) % 2) == 0) : 1'b1;
        return mk(m_health, m_dp, m_st == 1, vis, m_st == 2);
    endfunction

    task automatic drive(input bit r, input bit h, input bit he,
                         input string nm, input bit use_tab, input exp_t te);
        exp_t e;
        exp_t a;
        reset = r;
        hit   = h;
        heal  = he;
        model_step(r, h, he);
        sb.push_back(use_tab ? te : model_exp());
        @(posedge clock);
        #1;
        e = sb.pop_front();
        a = {health, damage_pulse, invulnerable, ship_visible, game_over};
        total++;
        if (a === e) begin
            passed++;
        end else begin
            $display("FAIL %s: got h=%0d dp=%b inv=%b vis=%b go=%b, want h=%0d dp=%b inv=%b vis=%b go=%b",
                     nm, a.health, a.dp, a.inv, a.vis, a.go,
                     e.health, e.dp, e.inv, e.vis, e.go);
        end
    endtask

    task automatic cyc(input bit h, input bit he, input string nm);
        drive(1'b0, h, he, nm, 1'b0, '0);
    endtask

    task automatic rst(input bit h, input string nm);
        drive(1'b1, h, 1'b0, nm, 1'b0, '0);
    endtask

    vec_t vt[16];

    initial begin
        // hit held high from the third vector: one point of damage, 8-cycle window
        vt[0]  = mv(1, 0, 0, mk(3, 0, 0, 1, 0));
        vt[1]  = mv(0, 0, 0, mk(3, 0, 0, 1, 0));
        vt[2]  = mv(0, 1, 0, mk(2, 1, 1, 1, 0));
        vt[3]  = mv(0, 1, 0, mk(2, 0, 1, 1, 0));
        vt[4]  = mv(0, 1, 0, mk(2, 0, 1, 0, 0));
        vt[5]  = mv(0, 1, 0, mk(2, 0, 1, 0, 0));
        vt[6]  = mv(0, 1, 0, mk(2, 0, 1, 1, 0));
        vt[7]  = mv(0, 1, 0, mk(2, 0, 1, 1, 0));
        vt[8]  = mv(0, 1, 0, mk(2, 0, 1, 0, 0));
        vt[9]  = mv(0, 1, 0, mk(2, 0, 1, 0, 0));
        vt[10] = mv(0, 1, 0, mk(2, 0, 0, 1, 0));
        vt[11] = mv(0, 1, 0, mk(2, 0, 0, 1, 0));
        vt[12] = mv(0, 1, 0, mk(2, 0, 0, 1, 0));
        vt[13] = mv(0, 0, 0, mk(2, 0, 0, 1, 0));
        vt[14] = mv(0, 1, 0, mk(1, 1, 1, 1, 0));
        vt[15] = mv(0, 0, 1, mk(2, 0, 1, 1, 0));

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].hit, vt[i].heal,
                  $sformatf("vec%0d", i), 1'b1, vt[i].e);
        end

        rst(0, "three_rst");
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, $sformatf("three_hit%0d", k));
            repeat (10) cyc(0, 0, "three_gap");
        end
        cyc(1, 0, "dead_hit");
        cyc(0, 1, "dead_heal");
        cyc(0, 0, "dead_idle");
        cyc(1, 1, "dead_both");
        cyc(0, 0, "dead_idle2");

        rst(0, "inv_rst");
        cyc(0, 0, "inv_idle");
        cyc(1, 0, "inv_hit");
        cyc(0, 0, "inv_low");
        cyc(1, 0, "inv_rise_ignored");
        repeat (8) cyc(1, 0, "inv_hold");
        cyc(0, 0, "inv_fall");
        cyc(1, 0, "inv_rehit");
        repeat (3) cyc(0, 0, "inv_after");

        rst(0, "heal_rst");
        cyc(0, 0, "heal_idle");
        cyc(0, 1, "heal_at_max");
        cyc(1, 0, "heal_hit");
        cyc(0, 0, "heal_gap");
        cyc(0, 1, "heal_in_inv");
        repeat (8) cyc(0, 0, "heal_window");

        rst(0, "both_rst");
        cyc(0, 0, "both_idle");
        cyc(1, 0, "both_hit1");
        repeat (9) cyc(0, 0, "both_gap1");
        cyc(1, 0, "both_hit2");
        repeat (9) cyc(0, 0, "both_gap2");
        cyc(1, 1, "both_rise_heal_h1");
        repeat (10) cyc(0, 0, "both_window");

        rst(0, "mid_rst0");
        cyc(0, 0, "mid_idle");
        cyc(1, 0, "mid_hit");
        repeat (3) cyc(1, 0, "mid_inv");
        rst(1, "mid_reset_hit_high");
        repeat (4) cyc(1, 0, "mid_hold");
        cyc(0, 0, "mid_fall");
        cyc(1, 0, "mid_rise");
        repeat (2) cyc(1, 0, "mid_after");

        begin
            bit h;
            h = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) h = ~h;
                drive($urandom_range(0, 59) == 0, h,
                      $urandom_range(0, 7) == 0,
                      "random", 1'b0, '0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
